// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan driver: double-buffered display word, per-digit
// dp/blanking, leading-zero suppression and dead time at the start of every slot.
module seg7_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 150000,
  parameter int BLANK_DEAD  = 4,
  parameter bit SEL_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  zero_sup,
  input  logic                  load,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]     DEAD_END   = PW'(BLANK_DEAD);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF    = {DIGITS{SEL_ACT_LOW}};
  localparam logic [7:0]        SEG_OFF    = {8{SEG_ACT_LOW}};

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t state, state_nxt;

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pend_data, shd_data;
  logic [DIGITS-1:0]   pend_dp, shd_dp;
  logic [DIGITS-1:0]   pend_blank, shd_blank;
  logic                pend_zs, shd_zs;
  logic [DIGITS-1:0]   sel_q, sel_nxt;
  logic [7:0]          seg_q, seg_nxt;
  logic                fd_q, fd_nxt;
  logic [DIGITS-1:0]   sup;
  logic                lead;
  logic [3:0]          nib;
  logic                scanning, start_scan, slot_end, frame_end;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h7E;
      4'h1: return 7'h30;
      4'h2: return 7'h6D;
      4'h3: return 7'h79;
      4'h4: return 7'h33;
      4'h5: return 7'h5B;
      4'h6: return 7'h5F;
      4'h7: return 7'h70;
      4'h8: return 7'h7F;
      4'h9: return 7'h7B;
      4'hA: return 7'h77;
      4'hB: return 7'h1F;
      4'hC: return 7'h4E;
      4'hD: return 7'h3D;
      4'hE: return 7'h4F;
      default: return 7'h47;
    endcase
  endfunction

  assign scanning   = (state == SCAN) && en;
  assign start_scan = (state == IDLE) && en;
  assign slot_end   = (presc == PRESC_LAST);
  assign frame_end  = slot_end && (idx == '0);
  assign nib        = shd_data[idx*4 +: 4];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = SCAN;
      SCAN:    if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Prescaler and digit index; both parked whenever not scanning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= IDX_LAST;
    end else if (!scanning) begin
      presc <= '0;
      idx   <= IDX_LAST;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= (idx == '0) ? IDX_LAST : idx - 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // load is a single-cycle strobe with no back-pressure: it is always accepted
  // into the pending set; the shadow set only changes at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_zs    <= 1'b0;
    end else if (load) begin
      pend_data  <= data;
      pend_dp    <= dp;
      pend_blank <= blank_mask;
      pend_zs    <= zero_sup;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_data  <= '0;
      shd_dp    <= '0;
      shd_blank <= '0;
      shd_zs    <= 1'b0;
    end else if (start_scan || (scanning && frame_end)) begin
      shd_data  <= pend_data;
      shd_dp    <= pend_dp;
      shd_blank <= pend_blank;
      shd_zs    <= pend_zs;
    end
  end

  // A digit stays suppressed while it and everything to its left is a bare zero.
  always_comb begin
    lead = 1'b1;
    sup  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead   = lead & (shd_data[4*i +: 4] == 4'h0) & ~shd_dp[i];
      sup[i] = lead & shd_zs & (i != 0);
    end
  end

  // FSM outputs (active-high, registered below)
  always_comb begin
    sel_nxt = '0;
    seg_nxt = '0;
    fd_nxt  = 1'b0;
    if (scanning) begin
      fd_nxt = frame_end;
      if (presc >= DEAD_END) begin
        sel_nxt[idx] = 1'b1;
        if (!(shd_blank[idx] || sup[idx]))
          seg_nxt = {shd_dp[idx], hex_to_seg(nib)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_OFF;
      seg_q <= SEG_OFF;
      fd_q  <= 1'b0;
    end else begin
      sel_q <= sel_nxt ^ SEL_OFF;
      seg_q <= seg_nxt ^ SEG_OFF;
      fd_q  <= fd_nxt;
    end
  end

  assign digit_sel  = sel_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule
